riscv_bp_ctrl: RTL and testbench
================================

Name: riscv_bp_ctrl

Overview:
- Sequencer and write-port arbiter for the correlating branch-prediction table, a 1R1W RAM of 2-bit entries addressed by {history, PC bits}.
- After reset, and on every flush request (fence.i, context switch), it sweeps every table entry to a programmable initial state.
- It arbitrates the RAM write port between the sweep and branch-unit updates, and tells the fetch side when predictions are valid.
- It sits between the branch unit / pipeline control and the predictor RAM write port.

Parameters:
- BP_GLOBAL_BITS, 2, global history bits in the table address
- BP_LOCAL_BITS, 10, PC-derived bits in the table address
- INIT_PREDICT, 2'b01, value written by the sweep (weakly not-taken; encoding 00<->01<->11<->10)
- Derived localparams: ADR_BITS = BP_GLOBAL_BITS+BP_LOCAL_BITS; DEPTH = 1<<ADR_BITS.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- bp_enable_i  in  1  predictor enable (CSR); low = predictions invalid, updates dropped
- flush_req_i  in  1  single-cycle or level request to reinitialise the table
- flush_busy_o  out  1  sweep in progress
- flush_done_o  out  1  one-cycle pulse after the last sweep write
- upd_valid_i  in  1  branch-unit update strobe
- upd_addr_i  in  ADR_BITS  update address {history, pc bits}
- upd_data_i  in  2  new 2-bit prediction
- upd_drop_o  out  1  one-cycle pulse: the update sampled in the previous cycle was discarded
- predict_valid_o  out  1  table contents usable by fetch
- ram_we_o  out  1  RAM write enable
- ram_waddr_o  out  ADR_BITS  RAM write address
- ram_wdata_o  out  2  RAM write data

Behaviour:
- All outputs are registered.
- Reset values (asserted asynchronously):
  - state=SWEEP, cnt=0
  - flush_busy_o=1, predict_valid_o=0
  - flush_done_o=0, upd_drop_o=0
  - ram_we_o=0, ram_waddr_o=0, ram_wdata_o=0
- FSM states: SWEEP, IDLE.
- SWEEP, each edge:
  - ram_we_o<=1, ram_waddr_o<=cnt, ram_wdata_o<=INIT_PREDICT, cnt<=cnt+1.
  - When cnt==DEPTH-1 is issued: next state IDLE, cnt wraps to 0.
  - The sweep is exactly DEPTH consecutive writes, addresses 0..DEPTH-1 in order, no gaps.
- SWEEP -> IDLE edge (the edge after the addr DEPTH-1 write is presented):
  - ram_we_o<=0, flush_busy_o<=0, flush_done_o<=1 for one cycle.
  - predict_valid_o<=bp_enable_i.
- IDLE, normal update: upd_valid_i=1, bp_enable_i=1, flush_req_i=0 at an edge -> next cycle ram_we_o=1, ram_waddr_o=upd_addr_i, ram_wdata_o=upd_data_i. Latency 1 cycle, one write per cycle, back-to-back supported.
- IDLE, no update: ram_we_o<=0.
- IDLE, flush_req_i=1:
  - next state SWEEP, cnt=0, flush_busy_o<=1, predict_valid_o<=0.
  - The first sweep write (addr 0) is presented at the second edge after sampling. The edge of sampling drives ram_we_o=0.
- Simultaneous flush_req_i and upd_valid_i in IDLE: flush wins, update discarded, upd_drop_o=1 next cycle.
- upd_valid_i during SWEEP: discarded (the table is being reinitialised), upd_drop_o=1 next cycle. The sweep is not disturbed.
- flush_req_i during SWEEP: coalesced, sweep continues without restart. This is correct because no updates are accepted during a sweep.
- bp_enable_i=0 in IDLE:
  - predict_valid_o<=0; upd_valid_i discarded with upd_drop_o=1; no RAM writes.
  - Re-enabling restores predict_valid_o=1 next edge; the table is not swept.
- bp_enable_i does not stop a sweep in progress.
- rst_i mid-sweep or mid-update: immediate return to reset values; a full sweep from addr 0 restarts after release.
- Counter width is ADR_BITS+1 or a wrap flag; DEPTH-1 detection must not overflow for any parameter set.

Test Plan:
- Reset release with BP_GLOBAL_BITS=1, BP_LOCAL_BITS=3 (DEPTH=16) -> 16 consecutive writes, addr 0..15, data 2'b01. flush_done_o pulses once the cycle after addr 15. flush_busy_o falls and predict_valid_o rises on the same edge.
- IDLE, upd_valid_i pulses with addr 5/data 2'b11 then addr 6/data 2'b10 back-to-back -> ram_we_o high two cycles with those addr/data, 1-cycle latency, upd_drop_o stays 0.
- flush_req_i and upd_valid_i (addr 3) high in the same IDLE cycle -> upd_drop_o=1 next cycle, no write to addr 3, full 16-write sweep follows, flush_done_o pulse at end.
- upd_valid_i every cycle plus a second flush_req_i during the sweep -> all updates dropped (one upd_drop_o per update), exactly 16 sweep writes, single flush_done_o.
- bp_enable_i=0 in IDLE with upd_valid_i -> no ram_we_o, upd_drop_o pulses, predict_valid_o=0. Re-enable -> predict_valid_o=1 next cycle, no sweep.
- rst_i asserted at sweep addr 9 -> outputs reach reset values asynchronously; after release the sweep restarts at addr 0 and completes all 16 entries.

Source files
------------

// File: rtl/riscv_bp_ctrl_if.sv
// riscv_bp_ctrl_if: branch-unit, pipeline-control and predictor-RAM write-port signals
interface riscv_bp_ctrl_if #(
  parameter int ADR_BITS = 12
);
  logic bp_enable_i;
  logic flush_req_i;
  logic flush_busy_o;
  logic flush_done_o;
  logic upd_valid_i;
  logic [ADR_BITS-1:0] upd_addr_i;
  logic [1:0] upd_data_i;
  logic upd_drop_o;
  logic predict_valid_o;
  logic ram_we_o;
  logic [ADR_BITS-1:0] ram_waddr_o;
  logic [1:0] ram_wdata_o;
  modport master (
    output bp_enable_i, flush_req_i, upd_valid_i, upd_addr_i, upd_data_i,
    input flush_busy_o, flush_done_o, upd_drop_o, predict_valid_o, ram_we_o, ram_waddr_o, ram_wdata_o
  );
  modport slave (
    input bp_enable_i, flush_req_i, upd_valid_i, upd_addr_i, upd_data_i,
    output flush_busy_o, flush_done_o, upd_drop_o, predict_valid_o, ram_we_o, ram_waddr_o, ram_wdata_o
  );
endinterface

// File: rtl/riscv_bp_ctrl.sv
// riscv_bp_ctrl: table sweep sequencer and write-port arbiter for the branch-prediction RAM
module riscv_bp_ctrl #(
  parameter int BP_GLOBAL_BITS = 2,
  parameter int BP_LOCAL_BITS = 10,
  parameter logic [1:0] INIT_PREDICT = 2'b01
) (
  input logic clk_i,
  input logic rst_i,
  riscv_bp_ctrl_if.slave bus
);
  localparam int ADR_BITS = BP_GLOBAL_BITS + BP_LOCAL_BITS;
  localparam logic [ADR_BITS:0] DEPTH = (ADR_BITS + 1)'(1) << ADR_BITS;
  typedef enum logic {SWEEP, IDLE} state_t;
  state_t state, state_n;
  // one extra bit lets cnt reach DEPTH, giving the finishing edge its own step
  logic [ADR_BITS:0] cnt, cnt_n;
  logic busy, busy_n, done, done_n, drop, drop_n, pv, pv_n, we, we_n;
  logic [ADR_BITS-1:0] waddr, waddr_n;
  logic [1:0] wdata, wdata_n;
  // state and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= SWEEP;
      cnt <= '0;
      busy <= 1'b1;
      done <= 1'b0;
      drop <= 1'b0;
      pv <= 1'b0;
      we <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      busy <= busy_n;
      done <= done_n;
      drop <= drop_n;
      pv <= pv_n;
      we <= we_n;
      waddr <= waddr_n;
      wdata <= wdata_n;
    end
  end
  // next state: sweep owns the write port until done, otherwise updates win unless a flush arrives
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    busy_n = busy;
    done_n = 1'b0;
    drop_n = 1'b0;
    pv_n = pv;
    we_n = 1'b0;
    waddr_n = waddr;
    wdata_n = wdata;
    if (state == SWEEP) begin
      drop_n = bus.upd_valid_i;
      if (cnt == DEPTH) begin
        state_n = IDLE;
        cnt_n = '0;
        busy_n = 1'b0;
        done_n = 1'b1;
        pv_n = bus.bp_enable_i;
      end else begin
        we_n = 1'b1;
        waddr_n = cnt[ADR_BITS-1:0];
        wdata_n = INIT_PREDICT;
        cnt_n = cnt + 1'b1;
      end
    end else if (bus.flush_req_i) begin
      state_n = SWEEP;
      cnt_n = '0;
      busy_n = 1'b1;
      pv_n = 1'b0;
      drop_n = bus.upd_valid_i;
    end else begin
      pv_n = bus.bp_enable_i;
      we_n = bus.upd_valid_i & bus.bp_enable_i;
      drop_n = bus.upd_valid_i & ~bus.bp_enable_i;
      waddr_n = we_n ? bus.upd_addr_i : waddr;
      wdata_n = we_n ? bus.upd_data_i : wdata;
    end
  end
  assign bus.flush_busy_o = busy;
  assign bus.flush_done_o = done;
  assign bus.upd_drop_o = drop;
  assign bus.predict_valid_o = pv;
  assign bus.ram_we_o = we;
  assign bus.ram_waddr_o = waddr;
  assign bus.ram_wdata_o = wdata;
endmodule

// File: tb/tb_riscv_bp_ctrl.sv
// tb_riscv_bp_ctrl: vector table, corner sequences and random traffic against a schedule-based model
module tb_riscv_bp_ctrl;
  localparam int AB = 4;
  localparam int DEPTH = 16;
  typedef struct packed {
    logic we;
    logic [3:0] addr;
    logic [1:0] data;
    logic drop;
    logic busy;
    logic done;
    logic pv;
  } out_t;
  typedef struct {
    logic en;
    logic fl;
    logic v;
    logic [3:0] a;
    logic [1:0] d;
    out_t exp;
  } vec_t;
  localparam out_t RST = '{1'b0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  riscv_bp_ctrl_if #(.ADR_BITS(AB)) bus();
  riscv_bp_ctrl #(.BP_GLOBAL_BITS(1), .BP_LOCAL_BITS(3), .INIT_PREDICT(2'b01)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );
  int n_tests = 0;
  int n_fail = 0;
  out_t q[$];
  out_t act, exp_o;
  logic [1:0] ref_tab[DEPTH];
  logic [1:0] ram[DEPTH];
  vec_t tbl[9];
  function automatic out_t sample();
    return '{bus.ram_we_o, bus.ram_waddr_o, bus.ram_wdata_o, bus.upd_drop_o,
             bus.flush_busy_o, bus.flush_done_o, bus.predict_valid_o};
  endfunction
  task automatic check_out(input string name, input out_t g, input out_t w, input bit mask);
    n_tests++;
    if (mask && !w.we) begin
      g.addr = '0;
      g.data = '0;
      w.addr = '0;
      w.data = '0;
    end
    if (g !== w) begin
      n_fail++;
      $display("FAIL %s: got we=%b addr=%0d data=%b drop=%b busy=%b done=%b pv=%b, want we=%b addr=%0d data=%b drop=%b busy=%b done=%b pv=%b",
               name, g.we, g.addr, g.data, g.drop, g.busy, g.done, g.pv,
               w.we, w.addr, w.data, w.drop, w.busy, w.done, w.pv);
    end
  endtask
  task automatic check_int(input string name, input int g, input int w);
    n_tests++;
    if (g !== w) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, g, w);
    end
  endtask
  // a reinitialisation is a fixed schedule: DEPTH in-order writes, then one finishing cycle
  task automatic schedule_sweep();
    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back('{1'b1, 4'(i), 2'b01, 1'b0, 1'b1, 1'b0, 1'b0});
    q.push_back('{1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0});
    foreach (ref_tab[i]) ref_tab[i] = 2'b01;
  endtask
  task automatic model_step(input logic en, input logic fl, input logic v, input logic [3:0] a, input logic [1:0] d);
    out_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      e.drop = v;
      if (e.done) e.pv = en;
    end else if (fl) begin
      e = '{1'b0, 4'd0, 2'b00, v, 1'b1, 1'b0, 1'b0};
      schedule_sweep();
    end else begin
      e = '{v & en, a, d, v & ~en, 1'b0, 1'b0, en};
      if (v && en) ref_tab[a] = d;
    end
    exp_o = e;
  endtask
  task automatic step(input logic en, input logic fl, input logic v, input logic [3:0] a, input logic [1:0] d,
                      input bit chk, input string name);
    bus.bp_enable_i = en;
    bus.flush_req_i = fl;
    bus.upd_valid_i = v;
    bus.upd_addr_i = a;
    bus.upd_data_i = d;
    model_step(en, fl, v, a, d);
    @(posedge clk);
    @(negedge clk);
    act = sample();
    if (act.we === 1'b1) ram[act.addr] = act.data;
    if (chk) check_out(name, act, exp_o, 1'b1);
  endtask
  initial begin
    int wr, dr, dn, first;
    bit found;
    tbl[0] = '{1'b1, 1'b0, 1'b1, 4'd5, 2'd3, '{1'b1, 4'd5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1}};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 4'd6, 2'd2, '{1'b1, 4'd6, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1}};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 4'd0, 2'd0, '{1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1}};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 4'd7, 2'd1, '{1'b0, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 4'd0, 2'd0, '{1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 4'd0, 2'd0, '{1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1}};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 4'd9, 2'd0, '{1'b1, 4'd9, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1}};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 4'd12, 2'd1, '{1'b1, 4'd12, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1}};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 4'd3, 2'd3, '{1'b0, 4'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0}};
    bus.bp_enable_i = 1'b1;
    bus.flush_req_i = 1'b0;
    bus.upd_valid_i = 1'b0;
    bus.upd_addr_i = '0;
    bus.upd_data_i = '0;
    @(negedge clk);
    check_out("reset", sample(), RST, 1'b0);
    rst = 1'b0;
    schedule_sweep();
    wr = 0;
    dn = 0;
    for (int c = 0; c < DEPTH + 1; c++) begin
      step(1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, "init_sweep");
      wr += int'(act.we);
      dn += int'(act.done);
    end
    check_int("init_writes", wr, DEPTH);
    check_int("init_done_pulses", dn, 1);
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].en, tbl[i].fl, tbl[i].v, tbl[i].a, tbl[i].d, 1'b0, "");
      check_out($sformatf("vec%0d", i), act, tbl[i].exp, 1'b1);
    end
    wr = 0;
    dr = 0;
    dn = 0;
    for (int c = 0; c < DEPTH + 1; c++) begin
      step(1'b1, c == 3 || c == 10, 1'b1, 4'(c), 2'(c), 1'b1, "sweep_busy");
      wr += int'(act.we);
      dr += int'(act.drop);
      dn += int'(act.done);
    end
    check_int("busy_writes", wr, DEPTH);
    check_int("busy_drops", dr, DEPTH + 1);
    check_int("busy_done_pulses", dn, 1);
    step(1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 1'b1, "flush3");
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step(1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, "sweep3");
      if (act.we && act.addr == 4'd9) found = 1'b1;
    end
    check_int("reach_addr9", int'(found), 1);
    #2 rst = 1'b1;
    #1 check_out("async_reset", sample(), RST, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    schedule_sweep();
    wr = 0;
    first = -1;
    for (int c = 0; c < DEPTH + 1; c++) begin
      step(1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, "resweep");
      if (act.we && first < 0) first = int'(act.addr);
      wr += int'(act.we);
    end
    check_int("restart_addr0", first, 0);
    check_int("restart_writes", wr, DEPTH);
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
           4'($urandom), 2'($urandom), 1'b1, "random");
    for (int c = 0; c < 40 && q.size() != 0; c++) step(1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, "drain");
    check_int("drained", q.size(), 0);
    foreach (ram[i]) check_int($sformatf("table%0d", i), int'(ram[i]), int'(ref_tab[i]));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
